// File: rtl/beep_pkg.sv
// Shared types and widths for the event beeper.
package beep_pkg;

  typedef enum logic [1:0] {IDLE, ON, GAP} beep_state_t;

  localparam int unsigned BEEP_N_W = 3;

endpackage

// File: rtl/evt_beeper.sv
// Event-to-indicator driver: plays N timed beeps (LED + square-wave buzzer) per request,
// with a one-deep pending slot for requests that arrive while a sequence is playing.
module evt_beeper
  import beep_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 5_000_000,
  parameter int unsigned OFF_CYCLES = 5_000_000,
  parameter int unsigned TONE_HALF  = 25_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trig,
  input  logic [BEEP_N_W-1:0] n_beeps,
  output logic                led,
  output logic                buzz,
  output logic                busy,
  output logic                drop
);

  localparam int unsigned PH_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(ON_CYCLES - 1);
  localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(OFF_CYCLES - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

  beep_state_t         state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [BEEP_N_W-1:0] rem_q, rem_d;
  logic                pend_vld_q, pend_vld_d;
  logic [BEEP_N_W-1:0] pend_n_q, pend_n_d;
  logic                led_q, buzz_q, buzz_d, busy_q, drop_q, drop_d;

  logic                req;
  logic                boundary;
  logic                start;
  logic [BEEP_N_W-1:0] start_n;

  always_comb begin
    req        = trig && (n_beeps != '0);
    state_d    = state_q;
    ph_d       = ph_q;
    rem_d      = rem_q;
    pend_vld_d = pend_vld_q;
    pend_n_d   = pend_n_q;
    drop_d     = 1'b0;
    start      = 1'b0;
    start_n    = rem_q;

    unique case (state_q)
      IDLE: ;
      ON: begin
        if (ph_q == ON_LAST) begin
          state_d = GAP;
          ph_d    = '0;
          rem_d   = rem_q - 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      GAP: begin
        if (ph_q == OFF_LAST) begin
          ph_d    = '0;
          state_d = (rem_q != '0) ? ON : IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new sequence may begin from IDLE or straight out of the final gap cycle.
    boundary = (state_q == IDLE) || (state_q == GAP && ph_q == OFF_LAST && rem_q == '0);

    if (boundary) begin
      if (pend_vld_q) begin
        start      = 1'b1;
        start_n    = pend_n_q;
        pend_vld_d = req;
        if (req) pend_n_d = n_beeps;
      end else if (req) begin
        start   = 1'b1;
        start_n = n_beeps;
      end
    end else if (req) begin
      drop_d     = pend_vld_q;
      pend_vld_d = 1'b1;
      pend_n_d   = n_beeps;
    end

    if (start) begin
      state_d = ON;
      ph_d    = '0;
      rem_d   = start_n;
    end
  end

  always_comb begin
    tone_d = '0;
    buzz_d = 1'b0;
    if (state_d == ON) begin
      if (state_q != ON) begin
        buzz_d = 1'b1;
      end else begin
        buzz_d = (tone_q == TONE_LAST) ? ~buzz_q : buzz_q;
        tone_d = (tone_q == TONE_LAST) ? '0 : tone_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      tone_q     <= '0;
      rem_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_n_q   <= '0;
      led_q      <= 1'b0;
      buzz_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      tone_q     <= tone_d;
      rem_q      <= rem_d;
      pend_vld_q <= pend_vld_d;
      pend_n_q   <= pend_n_d;
      led_q      <= (state_d == ON);
      buzz_q     <= buzz_d;
      busy_q     <= (state_d != IDLE);
      drop_q     <= drop_d;
    end
  end

  assign led  = led_q;
  assign buzz = buzz_q;
  assign busy = busy_q;
  assign drop = drop_q;

endmodule

// File: tb/tb_evt_beeper.sv
// Bench for evt_beeper: directed literal scenarios plus randomized traffic against a
// sequence-position model of the beep timeline.
module tb_evt_beeper;

  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 3;
  localparam int unsigned TH  = 2;
  localparam int          P   = ON + OFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [2:0] n_beeps = 3'd0;
  logic       led, buzz, busy, drop;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: current sequence length and position within it, plus the pending slot.
  int m_n = 0;
  int m_pos = 0;
  int m_pn = 0;
  bit m_pv = 1'b0;
  bit m_drop = 1'b0;

  evt_beeper #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .TONE_HALF (TH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig   (trig),
    .n_beeps(n_beeps),
    .led    (led),
    .buzz   (buzz),
    .busy   (busy),
    .drop   (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  initial begin : model
    bit req, act, last_c, start;
    int sn;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0; m_pos = 0; m_pv = 0; m_pn = 0; m_drop = 0;
      end else begin
        req    = trig && (n_beeps != 3'd0);
        act    = (m_n != 0);
        last_c = act && (m_pos == m_n * P - 1);
        m_drop = 0;
        start  = 0;
        sn     = 0;
        if (!act || last_c) begin
          if (m_pv) begin
            start = 1; sn = m_pn; m_pv = req;
            if (req) m_pn = int'(n_beeps);
          end else if (req) begin
            start = 1; sn = int'(n_beeps);
          end
        end else if (req) begin
          m_drop = m_pv; m_pv = 1; m_pn = int'(n_beeps);
        end
        if (start) begin
          m_n = sn; m_pos = 0;
        end else if (act) begin
          m_pos++;
          if (m_pos == m_n * P) begin
            m_n = 0; m_pos = 0;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int ph;
        bit e_busy, e_led, e_buzz;
        e_busy = (m_n != 0);
        ph     = m_pos % P;
        e_led  = e_busy && (ph < ON);
        e_buzz = e_led && (((ph / TH) % 2) == 0);
        check("model_led", led, e_led);
        check("model_buzz", buzz, e_buzz);
        check("model_busy", busy, e_busy);
        check("model_drop", drop, m_drop);
      end
    end
  end

  // Drive one cycle of inputs, then step to 1 time unit after the next rising edge.
  task automatic tick(input bit t, input logic [2:0] n);
    trig    = t;
    n_beeps = n;
    @(posedge clk);
    #1;
    trig    = 1'b0;
    n_beeps = 3'd0;
  endtask

  initial begin : main
    logic [8:1] exp_led, exp_buzz, exp_busy;
    exp_led  = 8'b0000_1111;
    exp_buzz = 8'b0000_0011;
    exp_busy = 8'b0111_1111;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_led", led, 1'b0);
    check("reset_buzz", buzz, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_drop", drop, 1'b0);
    repeat (2) tick(1'b0, 3'd0);

    // Single beep
    tick(1'b1, 3'd1);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick(1'b0, 3'd0);
      check("single_led", led, exp_led[k]);
      check("single_buzz", buzz, exp_buzz[k]);
      check("single_busy", busy, exp_busy[k]);
    end

    // Zero count is a no-op
    tick(1'b1, 3'd0);
    for (int k = 0; k < 3; k++) begin
      check("zero_busy", busy, 1'b0);
      check("zero_led", led, 1'b0);
      tick(1'b0, 3'd0);
    end

    // Pending request plays back-to-back
    tick(1'b1, 3'd1);
    repeat (2) tick(1'b0, 3'd0);
    tick(1'b1, 3'd2);
    repeat (3) tick(1'b0, 3'd0);
    check("pend_c7_busy", busy, 1'b1);
    check("pend_c7_led", led, 1'b0);
    tick(1'b0, 3'd0);
    check("pend_c8_led", led, 1'b1);
    repeat (13) tick(1'b0, 3'd0);
    check("pend_c21_busy", busy, 1'b1);
    tick(1'b0, 3'd0);
    check("pend_c22_busy", busy, 1'b0);
    repeat (3) tick(1'b0, 3'd0);

    // Trig in the last gap cycle
    tick(1'b1, 3'd1);
    repeat (6) tick(1'b0, 3'd0);
    check("bound_c7_busy", busy, 1'b1);
    tick(1'b1, 3'd1);
    check("bound_c8_busy", busy, 1'b1);
    check("bound_c8_led", led, 1'b1);
    check("bound_c8_buzz", buzz, 1'b1);
    repeat (6) tick(1'b0, 3'd0);
    check("bound_c14_busy", busy, 1'b1);
    tick(1'b0, 3'd0);
    check("bound_c15_busy", busy, 1'b0);
    repeat (3) tick(1'b0, 3'd0);

    // Overwrite of a full pending slot
    tick(1'b1, 3'd2);
    tick(1'b1, 3'd1);
    tick(1'b1, 3'd1);
    check("ovw_c3_drop", drop, 1'b1);
    tick(1'b0, 3'd0);
    check("ovw_c4_drop", drop, 1'b0);
    repeat (17) tick(1'b0, 3'd0);
    check("ovw_c21_busy", busy, 1'b1);
    tick(1'b0, 3'd0);
    check("ovw_c22_busy", busy, 1'b0);
    repeat (3) tick(1'b0, 3'd0);

    // Asynchronous reset mid-beep discards the pending slot
    tick(1'b1, 3'd3);
    tick(1'b1, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", led, 1'b0);
    check("rst_buzz", buzz, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) tick(1'b0, 3'd0);
    check("rst_after_busy", busy, 1'b0);
    check("rst_after_led", led, 1'b0);

    // Randomized traffic, with occasional asynchronous resets
    repeat (3000) begin
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      tick($urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)));
    end
    repeat (60) tick(1'b0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
